fp_adder_ctrl: RTL and testbench
================================

# fp_adder_ctrl

Sequencing controller for the floating-point adder datapath. It accepts one `start` pulse per operation and then drives all register strobes in order: it loads the A, B, R sign, exponent and mantissa registers, and the shift and count enables. Exponent alignment, add/subtract, normalization and sign selection are all decided from the datapath's status flags. It sits between the top-level wrapper and the datapath and contains no arithmetic of its own.

## Interface
- Parameters:
  - `NORM_MAX`, default 23: maximum left-normalization shifts per operation.
- Ports:
  - `clk`  in  1  clock, rising edge.
  - `rst`  in  1  reset, asynchronous, active-low.
  - `start`  in  1  operation request, sampled only in IDLE.
  - `eq_exp`, `lt_exp`, `gt_exp`  in  1 each  exponent compare, A vs B.
  - `eq_man`, `lt_man`, `gt_man`  in  1 each  mantissa compare, A vs B.
  - `signA_xor_signB`  in  1  sign difference. `operator` is already folded into B's sign upstream, so B's sign is `s_B ^ operator`.
  - `co_sum`  in  1  carry out of the mantissa adder.
  - `most_sig_man_R`, `or_man_R`  in  1 each  R mantissa bit 23, and OR-reduction of R mantissa.
  - `ld_s_A`, `ld_exp_A`, `ld_man_A`, `ld_s_B`, `ld_exp_B`, `ld_man_B`  out  1 each  operand loads.
  - `count_en_up_A`, `shift_man_right_A`, `count_en_up_B`, `shift_man_right_B`  out  1 each  alignment strobes.
  - `samesign`  out  1  1 selects the sum, 0 selects the difference.
  - `swap_sub`  out  1  difference computed as B−A instead of A−B.
  - `sel_sign_R`  out  2  sign source: 00 = +0, 01 = s_A, 10 = s_B, 11 = 1.
  - `ld_s_R`, `ld_exp_R`, `ld_man_R`  out  1 each  result loads.
  - `zero_result`  out  1  forces R exponent to 0 on `ld_exp_R`.
  - `shift_man_right_R`, `shift_man_left_R`, `count_en_up_R`, `count_en_down_R`  out  1 each  normalization strobes.
  - `busy`  out  1  high in every state except IDLE.
  - `done`  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, LOAD, ALIGN, ADD, NORM, DONE. Binary-encoded state register.
- Outputs are decoded combinationally from the state and the input flags. Outputs not listed for a state are 0.
- IDLE:
  - `start`=1 → LOAD; otherwise stay.
- LOAD:
  - All six A/B load strobes are 1.
  - → ALIGN.
- ALIGN, one cycle per step:
  - `lt_exp`: `shift_man_right_A`=1 and `count_en_up_A`=1.
  - `gt_exp`: `shift_man_right_B`=1 and `count_en_up_B`=1.
  - `eq_exp`: no strobe; → ADD.
- ADD:
  - `samesign` = ~`signA_xor_signB`.
  - `swap_sub` = `signA_xor_signB` & `lt_man`.
  - `ld_s_R`, `ld_exp_R`, `ld_man_R` are all 1.
  - `sel_sign_R` rules:
    - same sign: 01.
    - differing signs and `gt_man`: 01.
    - differing signs and `lt_man`: 10.
    - differing signs and `eq_man`: 00, with `zero_result`=1.
  - → NORM.
- NORM:
  - If `samesign` (held in a registered copy): when the registered `co_sum` is 1, issue one `shift_man_right_R` + `count_en_up_R` cycle (the datapath injects the carry at bit 23), then → DONE.
  - Otherwise, while `or_man_R`=1 & `most_sig_man_R`=0 and the internal shift count is < `NORM_MAX`: `shift_man_left_R` + `count_en_down_R`, count +1.
  - Exit to DONE when the MSB is 1, the mantissa is all zero, or the count reaches `NORM_MAX`.
  - The registered `zero_result` case skips NORM actions entirely.
- DONE:
  - `done`=1 → IDLE.
- Exponent overflow and underflow are not detected; the datapath counters wrap modulo 256.

## Timing
- Reset (`rst`=0, asynchronous):
  - State → IDLE, and the norm count, registered `samesign`, `co_sum` and `zero_result` are cleared.
  - Every output is 0, including `busy` and `done`.
- Reset mid-operation aborts immediately; there is no `done`.
- `start` is sampled in IDLE only. `start` while `busy` is ignored.
- Latency:
  - `start` sampled at edge 0 → `done` high in cycle 5 + d + n.
  - d = |expA − expB| (cycles spent aligning); n = normalization shifts (0..`NORM_MAX`, or 1 for a carry).
- `done` is high for exactly one cycle. `busy` falls in the same cycle `done` falls.
- Back-to-back operations: `start` held high in the cycle after DONE starts the next LOAD one cycle later.
- ALIGN flags are re-evaluated every cycle against the values updated at the previous edge. Exactly one of the A or B strobes is active per cycle, never both.
- At most one R shift direction is active per cycle. Up and down count are never both high.

## Test plan
- Equal exponents, same sign (1.5 + 1.5, mantissas 0xC00000, exp 127):
  - d=0; ADD sees `co_sum`=1 → one right shift + exp up; `done` at cycle 6; `sel_sign_R`=01.
- Exponent A=130, B=127:
  - exactly 3 cycles of `shift_man_right_B` + `count_en_up_B`, no A strobes; `done` at cycle 8 (with n=0).
- Differing signs, `lt_man`:
  - `swap_sub`=1, `sel_sign_R`=10; the difference 0x010000 yields 7 left-shift and down-count cycles.
- Differing signs, `eq_man`:
  - `sel_sign_R`=00, `zero_result`=1, no NORM strobes; `done` at cycle 5.
- Reset asserted during ALIGN (d=10, after 4 steps):
  - all outputs 0 immediately, no `done`; a later `start` runs a full operation normally.
- `start` pulsed while `busy`:
  - ignored; exactly one `done` per accepted `start`. Mantissa never normalizing within `NORM_MAX` (stuck flag) → exit after 23 shifts.

Source files
------------

// File: rtl/fp_adder_ctrl.sv
// rtl/fp_adder_ctrl.sv - sequencing controller for the floating-point adder datapath
// Decodes every datapath strobe from the FSM state and the datapath status flags.
module fp_adder_ctrl #(
  parameter int NORM_MAX = 23
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       eq_exp,
  input  logic       lt_exp,
  input  logic       gt_exp,
  input  logic       eq_man,
  input  logic       lt_man,
  input  logic       gt_man,
  input  logic       signA_xor_signB,
  input  logic       co_sum,
  input  logic       most_sig_man_R,
  input  logic       or_man_R,
  output logic       ld_s_A,
  output logic       ld_exp_A,
  output logic       ld_man_A,
  output logic       ld_s_B,
  output logic       ld_exp_B,
  output logic       ld_man_B,
  output logic       count_en_up_A,
  output logic       shift_man_right_A,
  output logic       count_en_up_B,
  output logic       shift_man_right_B,
  output logic       samesign,
  output logic       swap_sub,
  output logic [1:0] sel_sign_R,
  output logic       ld_s_R,
  output logic       ld_exp_R,
  output logic       ld_man_R,
  output logic       zero_result,
  output logic       shift_man_right_R,
  output logic       shift_man_left_R,
  output logic       count_en_up_R,
  output logic       count_en_down_R,
  output logic       busy,
  output logic       done
);

  localparam int CW = (NORM_MAX < 1) ? 1 : $clog2(NORM_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ALIGN = 3'd2,
    S_ADD   = 3'd3,
    S_NORM  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t          state;
  logic [CW-1:0]   norm_cnt;
  logic            samesign_r;
  logic            co_r;
  logic            zero_r;
  logic            align_done;
  logic            add_zero;
  logic            carry_pending;
  logic            can_shift_left;

  assign align_done     = eq_exp | ~(lt_exp | gt_exp);
  // Exactly cancelling operands: only when signs differ and neither mantissa wins.
  assign add_zero       = signA_xor_signB & ~gt_man & ~lt_man & eq_man;
  assign carry_pending  = samesign_r & co_r;
  assign can_shift_left = or_man_R & ~most_sig_man_R & (norm_cnt < CW'(NORM_MAX));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      norm_cnt   <= '0;
      samesign_r <= 1'b0;
      co_r       <= 1'b0;
      zero_r     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) state <= S_LOAD;
        end
        S_LOAD: begin
          state <= S_ALIGN;
        end
        S_ALIGN: begin
          if (align_done) state <= S_ADD;
        end
        S_ADD: begin
          samesign_r <= ~signA_xor_signB;
          co_r       <= co_sum & ~signA_xor_signB;
          zero_r     <= add_zero;
          norm_cnt   <= '0;
          state      <= S_NORM;
        end
        S_NORM: begin
          // After the carry shift the MSB is set, so the left loop exits next cycle.
          if (zero_r) begin
            state <= S_DONE;
          end else if (carry_pending) begin
            co_r <= 1'b0;
          end else if (can_shift_left) begin
            norm_cnt <= norm_cnt + CW'(1);
          end else begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    ld_s_A            = 1'b0;
    ld_exp_A          = 1'b0;
    ld_man_A          = 1'b0;
    ld_s_B            = 1'b0;
    ld_exp_B          = 1'b0;
    ld_man_B          = 1'b0;
    count_en_up_A     = 1'b0;
    shift_man_right_A = 1'b0;
    count_en_up_B     = 1'b0;
    shift_man_right_B = 1'b0;
    samesign          = 1'b0;
    swap_sub          = 1'b0;
    sel_sign_R        = 2'b00;
    ld_s_R            = 1'b0;
    ld_exp_R          = 1'b0;
    ld_man_R          = 1'b0;
    zero_result       = 1'b0;
    shift_man_right_R = 1'b0;
    shift_man_left_R  = 1'b0;
    count_en_up_R     = 1'b0;
    count_en_down_R   = 1'b0;
    busy              = (state != S_IDLE);
    done              = (state == S_DONE);

    case (state)
      S_LOAD: begin
        ld_s_A   = 1'b1;
        ld_exp_A = 1'b1;
        ld_man_A = 1'b1;
        ld_s_B   = 1'b1;
        ld_exp_B = 1'b1;
        ld_man_B = 1'b1;
      end
      S_ALIGN: begin
        // The smaller exponent is stepped up one per cycle; only one side moves.
        if (!align_done) begin
          if (lt_exp) begin
            shift_man_right_A = 1'b1;
            count_en_up_A     = 1'b1;
          end else begin
            shift_man_right_B = 1'b1;
            count_en_up_B     = 1'b1;
          end
        end
      end
      S_ADD: begin
        samesign    = ~signA_xor_signB;
        swap_sub    = signA_xor_signB & lt_man;
        ld_s_R      = 1'b1;
        ld_exp_R    = 1'b1;
        ld_man_R    = 1'b1;
        zero_result = add_zero;
        if (!signA_xor_signB || gt_man) begin
          sel_sign_R = 2'b01;
        end else if (lt_man) begin
          sel_sign_R = 2'b10;
        end else if (eq_man) begin
          sel_sign_R = 2'b00;
        end else begin
          sel_sign_R = 2'b01;
        end
      end
      S_NORM: begin
        if (!zero_r) begin
          if (carry_pending) begin
            shift_man_right_R = 1'b1;
            count_en_up_R     = 1'b1;
          end else if (can_shift_left) begin
            shift_man_left_R = 1'b1;
            count_en_down_R  = 1'b1;
          end
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_fp_adder_ctrl.sv
// tb/tb_fp_adder_ctrl.sv - self-checking bench for fp_adder_ctrl
// A small datapath model answers the strobes; expectations come from arithmetic rules.
module tb_fp_adder_ctrl;

  localparam int NORM_MAX = 23;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic eq_exp, lt_exp, gt_exp, eq_man, lt_man, gt_man;
  logic signA_xor_signB, co_sum, most_sig_man_R, or_man_R;
  logic ld_s_A, ld_exp_A, ld_man_A, ld_s_B, ld_exp_B, ld_man_B;
  logic count_en_up_A, shift_man_right_A, count_en_up_B, shift_man_right_B;
  logic samesign, swap_sub;
  logic [1:0] sel_sign_R;
  logic ld_s_R, ld_exp_R, ld_man_R, zero_result;
  logic shift_man_right_R, shift_man_left_R, count_en_up_R, count_en_down_R;
  logic busy, done;

  always #5 clk = ~clk;

  fp_adder_ctrl #(.NORM_MAX(NORM_MAX)) dut (
    .clk(clk), .rst(rst), .start(start),
    .eq_exp(eq_exp), .lt_exp(lt_exp), .gt_exp(gt_exp),
    .eq_man(eq_man), .lt_man(lt_man), .gt_man(gt_man),
    .signA_xor_signB(signA_xor_signB), .co_sum(co_sum),
    .most_sig_man_R(most_sig_man_R), .or_man_R(or_man_R),
    .ld_s_A(ld_s_A), .ld_exp_A(ld_exp_A), .ld_man_A(ld_man_A),
    .ld_s_B(ld_s_B), .ld_exp_B(ld_exp_B), .ld_man_B(ld_man_B),
    .count_en_up_A(count_en_up_A), .shift_man_right_A(shift_man_right_A),
    .count_en_up_B(count_en_up_B), .shift_man_right_B(shift_man_right_B),
    .samesign(samesign), .swap_sub(swap_sub), .sel_sign_R(sel_sign_R),
    .ld_s_R(ld_s_R), .ld_exp_R(ld_exp_R), .ld_man_R(ld_man_R),
    .zero_result(zero_result),
    .shift_man_right_R(shift_man_right_R), .shift_man_left_R(shift_man_left_R),
    .count_en_up_R(count_en_up_R), .count_en_down_R(count_en_down_R),
    .busy(busy), .done(done)
  );

  logic [23:0] outs;
  assign outs = {ld_s_A, ld_exp_A, ld_man_A, ld_s_B, ld_exp_B, ld_man_B,
                 count_en_up_A, shift_man_right_A, count_en_up_B, shift_man_right_B,
                 samesign, swap_sub, sel_sign_R, ld_s_R, ld_exp_R, ld_man_R, zero_result,
                 shift_man_right_R, shift_man_left_R, count_en_up_R, count_en_down_R,
                 busy, done};

  // Datapath model: operand registers, exponent counters and the R mantissa shifter.
  logic [7:0]  pa = 8'd0, pb = 8'd0, exp_a = 8'd0, exp_b = 8'd0;
  logic [23:0] p_r = 24'd0, man_r = 24'd0;
  bit          cur_sx = 1'b0, cur_co = 1'b0, cur_stuck = 1'b0;
  int          cur_rel = 1;

  always @(posedge clk) begin
    if (ld_exp_A) exp_a <= pa;
    else if (count_en_up_A) exp_a <= exp_a + 8'd1;
    if (ld_exp_B) exp_b <= pb;
    else if (count_en_up_B) exp_b <= exp_b + 8'd1;
    if (ld_man_R) man_r <= p_r;
    else if (shift_man_left_R) man_r <= man_r << 1;
    else if (shift_man_right_R) man_r <= {1'b1, man_r[23:1]};
  end

  assign eq_exp          = (exp_a == exp_b);
  assign lt_exp          = (exp_a < exp_b);
  assign gt_exp          = (exp_a > exp_b);
  assign lt_man          = (cur_rel == 0);
  assign eq_man          = (cur_rel == 1);
  assign gt_man          = (cur_rel == 2);
  assign signA_xor_signB = cur_sx;
  assign co_sum          = cur_co;
  assign most_sig_man_R  = cur_stuck ? 1'b0 : man_r[23];
  assign or_man_R        = cur_stuck ? 1'b1 : (man_r != 24'd0);

  typedef struct {
    logic [7:0]  ea;
    logic [7:0]  eb;
    bit          sx;
    int          rel;
    bit          co;
    logic [23:0] rmant;
    bit          stuck;
    bit          noise;
    int          lat;
    int          na;
    int          nb;
    int          nl;
    int          nr;
    logic [1:0]  sel;
    bit          swap;
    bit          zero;
  } op_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic op_t mk(input logic [7:0] ea, input logic [7:0] eb, input bit sx,
                             input int rel, input bit co, input logic [23:0] rmant,
                             input bit stuck, input bit noise, input int lat, input int na,
                             input int nb, input int nl, input int nr, input logic [1:0] sel,
                             input bit swap, input bit zero);
    op_t o;
    o.ea = ea; o.eb = eb; o.sx = sx; o.rel = rel; o.co = co; o.rmant = rmant;
    o.stuck = stuck; o.noise = noise; o.lat = lat; o.na = na; o.nb = nb;
    o.nl = nl; o.nr = nr; o.sel = sel; o.swap = swap; o.zero = zero;
    return o;
  endfunction

  function automatic int lzc24(input logic [23:0] v);
    for (int i = 23; i >= 0; i--) if (v[i]) return 23 - i;
    return 24;
  endfunction

  function automatic op_t ref_model(input op_t o);
    op_t r = o;
    int d = (int'(o.ea) > int'(o.eb)) ? int'(o.ea) - int'(o.eb) : int'(o.eb) - int'(o.ea);
    r.na   = (o.ea < o.eb) ? d : 0;
    r.nb   = (o.ea > o.eb) ? d : 0;
    r.zero = o.sx && (o.rel == 1);
    r.swap = o.sx && (o.rel == 0);
    r.sel  = !o.sx ? 2'b01 : (o.rel == 0) ? 2'b10 : (o.rel == 1) ? 2'b00 : 2'b01;
    r.nr   = (!o.sx && o.co) ? 1 : 0;
    if (r.zero || r.nr != 0)   r.nl = 0;
    else if (o.stuck)          r.nl = NORM_MAX;
    else if (o.rmant == 24'd0) r.nl = 0;
    else                       r.nl = (lzc24(o.rmant) < NORM_MAX) ? lzc24(o.rmant) : NORM_MAX;
    r.lat = 5 + d + r.nl + r.nr;
    return r;
  endfunction

  // Called at a negedge with the FSM idle; returns at the negedge after done falls.
  task automatic run_op(input op_t o, input string tag);
    int cyc = 0, lat = 0, na = 0, nb = 0, nl = 0, nr = 0, nld = 0, nldr = 0, viol = 0;
    logic [1:0] sel = 2'b11;
    bit swap = 1'b0, zr = 1'b0, ss = 1'b0, seen = 1'b0;
    pa = o.ea; pb = o.eb; p_r = o.rmant;
    cur_sx = o.sx; cur_rel = o.rel; cur_co = o.co; cur_stuck = o.stuck;
    start = 1'b1;
    @(posedge clk);
    while (!seen && cyc < 200) begin
      @(negedge clk);
      cyc++;
      start = o.noise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (ld_s_A & ld_exp_A & ld_man_A & ld_s_B & ld_exp_B & ld_man_B) nld++;
      if (ld_s_R & ld_exp_R & ld_man_R) begin
        nldr++; sel = sel_sign_R; swap = swap_sub; zr = zero_result; ss = samesign;
      end
      if (shift_man_right_A & count_en_up_A) na++;
      if (shift_man_right_B & count_en_up_B) nb++;
      if (shift_man_left_R & count_en_down_R) nl++;
      if (shift_man_right_R & count_en_up_R) nr++;
      if ((shift_man_right_A != count_en_up_A) || (shift_man_right_B != count_en_up_B)) viol++;
      if ((shift_man_right_A | count_en_up_A) & (shift_man_right_B | count_en_up_B)) viol++;
      if ((shift_man_left_R & shift_man_right_R) | (count_en_up_R & count_en_down_R)) viol++;
      if (!busy) viol++;
      if (done) begin seen = 1'b1; lat = cyc; start = 1'b0; end
    end
    if (!seen) begin
      chk({tag, "_timeout"}, 0, 1);
      start = 1'b0; rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      return;
    end
    chk({tag, "_latency"}, lat, o.lat);
    chk({tag, "_align_a"}, na, o.na);
    chk({tag, "_align_b"}, nb, o.nb);
    chk({tag, "_norm_left"}, nl, o.nl);
    chk({tag, "_norm_right"}, nr, o.nr);
    chk({tag, "_ab_loads"}, nld, 1);
    chk({tag, "_r_loads"}, nldr, 1);
    chk({tag, "_sel_sign"}, int'(sel), int'(o.sel));
    chk({tag, "_swap_sub"}, int'(swap), int'(o.swap));
    chk({tag, "_zero_result"}, int'(zr), int'(o.zero));
    chk({tag, "_samesign"}, int'(ss), int'(!o.sx));
    chk({tag, "_strobe_rules"}, viol, 0);
    @(negedge clk);
    chk({tag, "_done_width"}, int'(done), 0);
    chk({tag, "_busy_fall"}, int'(busy), 0);
  endtask

  op_t tbl[8];

  initial begin
    op_t o;
    int dn;
    tbl[0] = mk(8'd127, 8'd127, 0, 1, 1, 24'h800000, 0, 0,  6, 0, 0,  0, 1, 2'b01, 0, 0);
    tbl[1] = mk(8'd130, 8'd127, 0, 2, 0, 24'hA00000, 0, 0,  8, 0, 3,  0, 0, 2'b01, 0, 0);
    tbl[2] = mk(8'd127, 8'd127, 1, 0, 0, 24'h010000, 0, 0, 12, 0, 0,  7, 0, 2'b10, 1, 0);
    tbl[3] = mk(8'd127, 8'd127, 1, 1, 0, 24'h000000, 0, 0,  5, 0, 0,  0, 0, 2'b00, 0, 1);
    tbl[4] = mk(8'd64,  8'd64,  1, 2, 0, 24'h000001, 1, 0, 28, 0, 0, 23, 0, 2'b01, 0, 0);
    tbl[5] = mk(8'd120, 8'd125, 1, 2, 1, 24'h400000, 0, 0, 11, 5, 0,  1, 0, 2'b01, 0, 0);
    tbl[6] = mk(8'd10,  8'd10,  1, 2, 0, 24'h000000, 0, 0,  5, 0, 0,  0, 0, 2'b01, 0, 0);
    tbl[7] = mk(8'd200, 8'd196, 1, 0, 0, 24'h020000, 0, 1, 15, 0, 4,  6, 0, 2'b10, 1, 0);

    rst = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", int'(outs), 0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_outputs", int'(outs), 0);

    for (int i = 0; i < 8; i++) run_op(tbl[i], $sformatf("vec%0d", i));

    // Reset while aligning a ten-step exponent gap, four steps in.
    pa = 8'd100; pb = 8'd110; cur_sx = 1'b0; cur_rel = 2; cur_co = 1'b0; cur_stuck = 1'b0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("midreset_aligning", int'(count_en_up_A & shift_man_right_A), 1);
    rst = 1'b0;
    #1;
    chk("midreset_outputs", int'(outs), 0);
    dn = 0;
    repeat (3) begin
      @(negedge clk);
      if (done || busy) dn++;
    end
    chk("midreset_quiet", dn, 0);
    rst = 1'b1;
    @(negedge clk);
    run_op(tbl[1], "after_reset");

    for (int i = 0; i < 40; i++) begin
      int e;
      o.ea    = 8'($urandom_range(20, 235));
      e       = int'(o.ea) + int'($urandom_range(0, 24)) - 12;
      o.eb    = 8'(e);
      o.sx    = 1'($urandom_range(0, 1));
      o.rel   = int'($urandom_range(0, 2));
      o.co    = 1'($urandom_range(0, 1));
      o.rmant = 24'($urandom) >> $urandom_range(0, 24);
      o.stuck = 1'b0;
      o.noise = ($urandom_range(0, 3) == 0);
      o = ref_model(o);
      run_op(o, $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
